// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - Receiver FSM state encodings (3-bit, legacy-compatible constants).
//   - Baud-count derivation helpers. Both directions call these so that
//     their bit timing always matches.
package uart_pkg;

    localparam int COUNT_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Cycles per bit minus one.
    function automatic int calc_full_bit_count(input int clk_frequency, input int baud_rate);
        return (clk_frequency / baud_rate) - 1;
    endfunction

    // Cycles from the start-bit edge to mid-bit, minus one.
    function automatic int calc_half_bit_count(input int clk_frequency, input int baud_rate);
        return ((clk_frequency / baud_rate) / 2) - 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so a freshly reset receiver sees an idle line.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   d_in   in   asynchronous input
//   d_out  out  synchronised copy of d_in (2 cycles of latency)
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic d_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-deep holding register.
// Samples each bit at its centre using a clock-count baud timer.
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   RX             in   asynchronous serial line, idle high
//   read           in   host acknowledge; clears rx_ready and both error flags
//   data_out       out  last correctly framed byte
//   rx_ready       out  data_out holds an unread byte (level)
//   framing_error  out  sticky: stop bit sampled low
//   overrun_error  out  sticky: byte completed while an unread byte was held
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | timing to mid start bit to confirm it is not a glitch
// DATA   | sampling 8 data bits, LSB first, one per full bit time
// STOP   | sampling the stop bit
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_frequency  = 50000000,
    parameter int baud_rate      = 9600,
    parameter int full_bit_count = calc_full_bit_count(clk_frequency, baud_rate),
    parameter int half_bit_count = calc_half_bit_count(clk_frequency, baud_rate)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    input  logic       read,
    output logic [7:0] data_out,
    output logic       rx_ready,
    output logic       framing_error,
    output logic       overrun_error
);

    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(full_bit_count);
    localparam logic [COUNT_W-1:0] HALF_CNT = COUNT_W'(half_bit_count);

    logic rx_s;

    logic [2:0]         state_q,   state_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q,   shift_d;
    logic [7:0]         data_q,    data_d;
    logic               ready_q,   ready_d;
    logic               fe_q,      fe_d;
    logic               oe_q,      oe_d;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (RX),
        .d_out (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = ready_q;
        fe_d      = fe_q;
        oe_d      = oe_q;

        // Host acknowledge comes first so that a byte or error landing in the
        // same cycle overrides the clear below.
        if (read) begin
            ready_d = 1'b0;
            fe_d    = 1'b0;
            oe_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    count_d = '0;
                end
            end

            ST_START: begin
                if (count_q == HALF_CNT) begin
                    count_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (count_q == FULL_CNT) begin
                    count_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (count_q == FULL_CNT) begin
                    count_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        // A read in this very cycle consumes the old byte.
                        if (ready_q && !read) begin
                            oe_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            fe_q      <= fe_d;
            oe_q      <= oe_d;
        end
    end

    assign data_out      = data_q;
    assign rx_ready      = ready_q;
    assign framing_error = fe_q;
    assign overrun_error = oe_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data_out;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun_error;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [7:0] last_good;
    logic       ok;

    uart_rx #(.clk_frequency(16), .baud_rate(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .RX            (rx),
        .read          (rd),
        .data_out      (data_out),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame. push: the byte is expected to become visible.
    // read_at_stop: pulse read in the cycle the receiver samples the stop bit
    // (start edge + 155 cycles: 2 sync + 1 + 8 start + 8*16 data + 16 stop).
    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input logic push, input logic read_at_stop);
        if (push) exp_q.push_back(b);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop_ok;
        for (int i = 0; i < BIT; i++) begin
            if (read_at_stop) rd = (i == 10);
            tick(1);
        end
        rd = 1'b0;
        rx = 1'b1;
    endtask

    task automatic wait_ready(output logic got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rx_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_read();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pop_exp(output logic [7:0] b);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected byte queued");
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rx_ready); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", overrun_error); end
        @(posedge clk); #1;
        tick(4);
    endtask

    task automatic test_normal();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL normal_timeout: rx_ready got 0 want 1"); end
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL normal_data: got %h want %h", data_out, exp_b); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL normal_fe: got %b want 0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL normal_oe: got %b want 0", overrun_error); end
        @(posedge clk); #1;
        pulse_read();
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL normal_read_clear: rx_ready got %b want 0", rx_ready); end
        @(posedge clk); #1;
        tick(4);
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * BIT);
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready: got %b want 0", rx_ready); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL glitch_fe: got %b want 0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL glitch_oe: got %b want 0", overrun_error); end
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL glitch_next_timeout: rx_ready got 0 want 1"); end
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL glitch_next_data: got %h want %h", data_out, exp_b); end
        @(posedge clk); #1;
        last_good = 8'h3C;
        pulse_read();
        tick(4);
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        tick(BIT);
        @(negedge clk);
        checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL framing_fe: got %b want 1", framing_error); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL framing_ready: got %b want 0", rx_ready); end
        checks++; if (data_out !== last_good) begin errors++; $display("FAIL framing_data_kept: got %h want %h", data_out, last_good); end
        @(posedge clk); #1;
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL framing_next_timeout: rx_ready got 0 want 1"); end
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL framing_next_data: got %h want %h", data_out, exp_b); end
        @(posedge clk); #1;
        pulse_read();
        @(negedge clk);
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_read_clear: fe got %b want 0", framing_error); end
        @(posedge clk); #1;
        tick(4);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        wait_ready(ok);
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL overrun_data: got %h want %h", data_out, exp_b); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL overrun_ready: got %b want 1", rx_ready); end
        checks++; if (overrun_error !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun_error); end
        @(posedge clk); #1;
        pulse_read();
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL overrun_clear_ready: got %b want 0", rx_ready); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL overrun_clear_flag: got %b want 0", overrun_error); end
        @(posedge clk); #1;
        tick(4);
    endtask

    task automatic test_read_collision();
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL collision_first_timeout: rx_ready got 0 want 1"); end
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL collision_first_data: got %h want %h", data_out, exp_b); end
        @(posedge clk); #1;
        send_frame(8'h7E, 1'b1, 1'b1, 1'b1);
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL collision_data: got %h want %h", data_out, exp_b); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL collision_ready: got %b want 1", rx_ready); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL collision_oe: got %b want 0", overrun_error); end
        @(posedge clk); #1;
        tick(4);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hF0;
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = b[3];
        tick(8);
        reset = 1'b1;
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", data_out); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", rx_ready); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL midreset_fe: got %b want 0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL midreset_oe: got %b want 0", overrun_error); end
        @(posedge clk); #1;
        tick(2 * BIT);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midreset_next_timeout: rx_ready got 0 want 1"); end
        pop_exp(exp_b);
        @(negedge clk);
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL midreset_next_data: got %h want %h", data_out, exp_b); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL midreset_next_oe: got %b want 0", overrun_error); end
        @(posedge clk); #1;
    endtask

    initial begin
        last_good = 8'h00;
        test_reset();
        test_normal();
        test_glitch();
        test_framing();
        test_overrun();
        test_read_collision();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
